// File: rtl/ex_mem_stage.sv
// ex_mem_stage: LEGv8 execute + memory-access slice with EX/MEM and MEM/WB registers
module ex_mem_stage #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic [31:0] instr,
  input  logic [63:0] sext_imm,
  input  logic [63:0] rd_data1,
  input  logic [63:0] rd_data2,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  output logic [63:0] branch_target,
  output logic        pc_src,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg,
  output logic [63:0] wb_data,
  output logic        alu_err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [3:0] C_AND = 4'b0000, C_ORR = 4'b0001, C_ADD = 4'b0010, C_SUB = 4'b0110;
  localparam logic [3:0] C_PASS = 4'b0111, C_NOR = 4'b1100, C_ILL = 4'b1111;
  logic [10:0] opcode;
  logic [3:0]  ctl;
  logic        illegal;
  logic [63:0] b, result;
  always_comb begin
    opcode  = instr[31:21];
    ctl     = alu_op == 2'b00 ? C_ADD :
              alu_op == 2'b01 ? C_PASS :
              alu_op == 2'b11 ? C_NOR :
              opcode == OP_ADD ? C_ADD :
              opcode == OP_SUB ? C_SUB :
              opcode == OP_AND ? C_AND :
              opcode == OP_ORR ? C_ORR : C_ILL;
    illegal = ctl == C_ILL;
    b       = alu_src ? sext_imm : rd_data2;
    result  = ctl == C_AND  ? rd_data1 & b :
              ctl == C_ORR  ? rd_data1 | b :
              ctl == C_ADD  ? rd_data1 + b :
              ctl == C_SUB  ? rd_data1 - b :
              ctl == C_PASS ? b :
              ctl == C_NOR  ? ~(rd_data1 | b) : 64'd0;
  end
  logic [63:0] m_result, m_store;
  logic        m_mem_write, m_mem_to_reg, m_reg_write;
  logic [4:0]  m_rd;
  always_ff @(posedge clk) begin
    if (reset) begin
      m_result      <= '0;
      m_store       <= '0;
      m_mem_write   <= 1'b0;
      m_mem_to_reg  <= 1'b0;
      m_reg_write   <= 1'b0;
      m_rd          <= '0;
      branch_target <= '0;
      pc_src        <= 1'b0;
      alu_err       <= 1'b0;
    end else begin
      m_result      <= result;
      m_store       <= rd_data2;
      m_mem_write   <= mem_write & ~illegal;
      m_mem_to_reg  <= mem_to_reg;
      m_reg_write   <= reg_write & ~illegal;
      m_rd          <= instr[4:0];
      branch_target <= pc_in + (sext_imm << 2);
      pc_src        <= branch & (result == 64'd0);
      alu_err       <= illegal;
    end
  end
  logic [63:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  assign idx = m_result[AW+2:3];
  // Reset gates the write so a store caught in EX/MEM is squashed
  always_ff @(posedge clk) begin
    if (!reset && m_mem_write) mem[idx] <= m_store;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_reg_write <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
    end else begin
      wb_reg_write <= m_reg_write;
      wb_reg       <= m_rd;
      wb_data      <= m_mem_to_reg ? mem[idx] : m_result;
    end
  end
  logic unused;
  assign unused = ^{instr[20:5], mem_read};
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized bench against a behavioural model, plus literal directed checks
module tb_ex_mem_stage;
  logic        clk = 0, reset = 1;
  logic [63:0] pc_in = 0, sext_imm = 0, rd_data1 = 0, rd_data2 = 0;
  logic [31:0] instr = 0;
  logic        alu_src = 0, branch = 0, mem_read = 0, mem_write = 0, mem_to_reg = 0, reg_write = 0;
  logic [1:0]  alu_op = 0;
  logic [63:0] branch_target, wb_data;
  logic        pc_src, wb_reg_write, alu_err;
  logic [4:0]  wb_reg;
  int errs = 0, checks = 0;
  bit live = 0;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr(instr), .sext_imm(sext_imm),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .alu_src(alu_src), .alu_op(alu_op),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch_target(branch_target), .pc_src(pc_src),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data), .alu_err(alu_err)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000, ORR = 11'b10101010000;

  typedef struct {
    logic [63:0] res, tgt, st;
    logic pcs, err, rw, mw, mtr;
    logic [4:0] rd;
  } ex_t;

  ex_t s1;
  logic [63:0] e_wdata;
  logic        e_wrw;
  logic [4:0]  e_wrd;
  logic [63:0] mmem [128];

  function automatic ex_t model_ex();
    ex_t e;
    logic [63:0] bb, r;
    logic ill;
    bb = alu_src ? sext_imm : rd_data2;
    ill = 0;
    r = 0;
    if (alu_op == 0) r = rd_data1 + bb;
    else if (alu_op == 1) r = bb;
    else if (alu_op == 3) r = ~(rd_data1 | bb);
    else if (instr[31:21] == ADD) r = rd_data1 + bb;
    else if (instr[31:21] == SUB) r = rd_data1 - bb;
    else if (instr[31:21] == AND) r = rd_data1 & bb;
    else if (instr[31:21] == ORR) r = rd_data1 | bb;
    else ill = 1;
    e.res = r;
    e.err = ill;
    e.tgt = pc_in + sext_imm * 4;
    e.pcs = branch && r == 0;
    e.st  = rd_data2;
    e.rw  = reg_write && !ill;
    e.mw  = mem_write && !ill;
    e.mtr = mem_to_reg;
    e.rd  = instr[4:0];
    return e;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      s1 = '{default: 0};
      e_wdata = 0; e_wrw = 0; e_wrd = 0;
    end else begin
      e_wdata = s1.mtr ? mmem[s1.res[9:3]] : s1.res;
      e_wrw = s1.rw;
      e_wrd = s1.rd;
      if (s1.mw) mmem[s1.res[9:3]] = s1.st;
      s1 = model_ex();
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("m_branch_target", branch_target, s1.tgt);
      chk("m_pc_src", {63'd0, pc_src}, {63'd0, s1.pcs});
      chk("m_alu_err", {63'd0, alu_err}, {63'd0, s1.err});
      chk("m_wb_reg_write", {63'd0, wb_reg_write}, {63'd0, e_wrw});
      chk("m_wb_reg", {59'd0, wb_reg}, {59'd0, e_wrd});
      chk("m_wb_data", wb_data, e_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    instr = 0; alu_op = 0; alu_src = 0; branch = 0; mem_read = 0; mem_write = 0;
    mem_to_reg = 0; reg_write = 0; rd_data1 = 0; rd_data2 = 0; sext_imm = 0; pc_in = 0;
  endtask

  task automatic rtype(input logic [10:0] op, input logic [63:0] a, input logic [63:0] bv, input logic [4:0] rd);
    nop();
    instr = {op, 16'd0, rd}; alu_op = 2'b10; rd_data1 = a; rd_data2 = bv; reg_write = 1;
  endtask

  task automatic mem_op(input bit st, input logic [63:0] a, input logic [63:0] imm, input logic [63:0] d, input logic [4:0] rd);
    nop();
    instr = {11'd0, 16'd0, rd}; alu_src = 1; rd_data1 = a; sext_imm = imm; rd_data2 = d;
    mem_write = st; mem_read = !st; mem_to_reg = !st; reg_write = !st;
  endtask

  logic [10:0] ops [5];

  initial begin
    ops[0] = ADD; ops[1] = SUB; ops[2] = AND; ops[3] = ORR; ops[4] = 11'b11111111111;
    for (int i = 0; i < 128; i++) mmem[i] = 0;
    nop();
    step(); step();
    live = 1;
    chk("reset_wb_data", wb_data, 0);
    chk("reset_target", branch_target, 0);
    chk("reset_flags", {61'd0, pc_src, alu_err, wb_reg_write}, 0);
    reset = 0;
    for (int i = 0; i < 128; i++) begin
      mem_op(1, 0, 64'(i * 8), {$urandom, $urandom}, 0);
      step();
    end
    nop(); step(); step();
    rtype(ADD, 5, 7, 3); step();
    rtype(SUB, 0, 1, 4); step();
    chk("add_data", wb_data, 12);
    chk("add_reg", {59'd0, wb_reg}, 3);
    chk("add_rw", {63'd0, wb_reg_write}, 1);
    rtype(ORR, 64'hF0, 64'h0F, 6); step();
    chk("sub_underflow", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    rtype(AND, 64'hF0, 64'h0F, 8); step();
    chk("orr", wb_data, 64'hFF);
    nop(); step();
    chk("and", wb_data, 0);
    mem_op(1, 64'h10, 8, 64'hDEAD_BEEF, 0); step();
    mem_op(0, 64'h10, 8, 0, 5); step();
    nop(); step();
    chk("ldur_data", wb_data, 64'hDEAD_BEEF);
    chk("ldur_reg", {59'd0, wb_reg}, 5);
    nop(); alu_op = 2'b01; branch = 1; pc_in = 64'h100; sext_imm = 4; rd_data2 = 0; step();
    chk("cbz_taken", {63'd0, pc_src}, 1);
    chk("cbz_target", branch_target, 64'h110);
    rd_data2 = 1; step();
    chk("cbz_not_taken", {63'd0, pc_src}, 0);
    rtype(11'b11111111111, 3, 4, 7); step();
    chk("illegal_err", {63'd0, alu_err}, 1);
    nop(); step();
    chk("illegal_rw", {63'd0, wb_reg_write}, 0);
    chk("illegal_data", wb_data, 0);
    mem_op(1, 64'h40, 0, 64'h1111_2222, 0); step();
    nop(); step();
    mem_op(1, 64'h40, 0, 64'h3333_4444, 0); step();
    nop(); reset = 1; step();
    chk("rst_mid_data", wb_data, 0);
    chk("rst_mid_flags", {61'd0, pc_src, alu_err, wb_reg_write}, 0);
    chk("rst_mid_target", branch_target, 0);
    reset = 0;
    mem_op(0, 64'h40, 0, 0, 9); step();
    nop(); step();
    chk("store_dropped", wb_data, 64'h1111_2222);
    for (int i = 0; i < 600; i++) begin
      nop();
      reset = ($urandom_range(0, 59) == 0);
      instr = {ops[$urandom_range(0, 4)], 16'($urandom), 5'($urandom)};
      alu_op = 2'($urandom);
      alu_src = 1'($urandom);
      branch = 1'($urandom);
      mem_read = 1'($urandom);
      mem_write = 1'($urandom);
      mem_to_reg = 1'($urandom);
      reg_write = 1'($urandom);
      pc_in = {$urandom, $urandom};
      sext_imm = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 64)) : {$urandom, $urandom};
      rd_data1 = $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom, $urandom};
      rd_data2 = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 1)) : {$urandom, $urandom};
      step();
    end
    reset = 0; nop(); step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
